decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter BEATS_0, default 8, input beats per frame for code 0.
REQ-002 SHALL have parameter BEATS_1, default 8, beats for code 1.
REQ-003 SHALL have parameter BEATS_2, default 32, beats for code 2.
REQ-004 SHALL have parameter BEATS_3, default 128, beats for code 3.
REQ-005 SHALL have parameter CNT_W, default 8, beat counter width; every BEATS_n SHALL be between 1 and 2^CNT_W.
REQ-006 i_clk  input  1  single clock, rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_core_set  input  1  start new frame, latch mode and code.
REQ-009 i_core_mode  input  1  0 = hard decision, 1 = soft decision.
REQ-010 i_core_code  input  2  code select, indexes BEATS_0..BEATS_3.
REQ-011 i_in_valid  input  1  upstream beat present.
REQ-012 o_core_ready  output  1  sequencer accepts a beat this cycle.
REQ-013 o_mode / o_code  output  1 / 2  latched mode and code.
REQ-014 o_error_bit_saver_clear  output  1  clear pulse to error-bit store.
REQ-015 o_syndrome_clear_and_wen  output  1  first-beat syndrome overwrite strobe.
REQ-016 o_syndrome_wen  output  1  syndrome accumulate strobe.
REQ-017 o_llr_mem_wen  output  1  LLR memory write strobe.
REQ-018 o_beat_idx  output  CNT_W  index of the beat being written.
REQ-019 o_dec_start  output  1  one-cycle decoder start pulse.
REQ-020 i_dec_done  input  1  decoder finished.
REQ-021 o_out_valid / i_out_ready  output / input  1 / 1  result handshake.
REQ-022 o_busy  output  1  high in every state except IDLE.

Function
REQ-023 The FSM SHALL have the states IDLE, CLEAR, LOAD, DECODE and OUT.
REQ-024 i_core_set SHALL take priority over all other inputs in every state: mode and code latch, the next state is CLEAR, and every pending strobe and start pulse of the aborted frame is cancelled.
REQ-025 CLEAR SHALL last exactly one cycle with o_error_bit_saver_clear=1, then enter LOAD with the beat counter at 0.
REQ-026 In LOAD o_core_ready SHALL be 1, and a beat is accepted in each cycle where o_core_ready and i_in_valid are both 1; i_in_valid=0 stalls without advancing.
REQ-027 Write strobes SHALL be registered and asserted exactly one cycle after acceptance, with o_beat_idx equal to the accepted beat's counter value.
REQ-028 For each accepted beat o_syndrome_wen=1; o_syndrome_clear_and_wen=1 only for beat 0.
REQ-029 o_llr_mem_wen SHALL equal o_syndrome_wen AND latched mode.
REQ-030 The counter SHALL increment per acceptance, and acceptance of beat BEATS_n-1 SHALL move the FSM to DECODE; the counter SHALL NOT wrap.
REQ-031 o_dec_start SHALL pulse exactly 2 cycles after the final acceptance.
REQ-032 i_dec_done SHALL be ignored until the cycle after o_dec_start; once seen, the FSM SHALL enter OUT.
REQ-033 In OUT o_out_valid SHALL be 1 and held until i_out_ready=1, then the FSM SHALL enter IDLE; i_out_ready=1 on the entry cycle completes at once.
REQ-034 In IDLE all strobes and o_core_ready SHALL be 0, and i_dec_done, i_in_valid and i_out_ready SHALL be ignored.

Reset
REQ-035 While i_rst_n=0, independent of i_clk: state IDLE, counter 0, mode 0, code 0, all outputs 0.
REQ-036 Reset mid-frame SHALL discard the frame; no strobe or start pulse appears after release until a new i_core_set.

Configuration
REQ-037 With SEQ_SOFT_EN defined, soft mode SHALL operate per REQ-029.
REQ-038 Without SEQ_SOFT_EN, latched mode SHALL be forced to 0, o_mode=0 and o_llr_mem_wen constant 0; all other behaviour is unchanged.

Verification
REQ-039 Code 0, mode 1, i_in_valid constant 1: clear at cycle 1, eight strobes with idx 0..7, clear_and_wen only on idx 0, llr_wen on all eight, dec_start 2 cycles after 8th acceptance.
REQ-040 Code 3, mode 0, i_in_valid low every third cycle: exactly 128 strobes, idx contiguous 0..127, llr_wen never 1.
REQ-041 i_core_set at beat 20 of code 2: no strobe in the following cycle, clear pulse, strobes restart at idx 0, o_dec_start only after 32 new beats.
REQ-042 i_dec_done pulsed before o_dec_start, then 5 cycles after it: only the second pulse moves the FSM to OUT; o_out_valid held 4 cycles with i_out_ready low, then IDLE with o_busy=0.
REQ-043 i_rst_n low during LOAD at beat 50: outputs 0 immediately, and no activity after release without i_core_set.
REQ-044 SEQ_SOFT_EN undefined, mode 1 set: o_mode=0 and o_llr_mem_wen=0 throughout the frame.

Source files
------------

// File: rtl/decode_sequencer.sv
// Frame sequencer for the decoder: clears the error-bit store, loads the frame's beats,
// starts the decoder and holds the result handshake. Define SEQ_SOFT_EN to enable soft-decision LLR writes.
module decode_sequencer #(
  parameter int BEATS_0 = 8,
  parameter int BEATS_1 = 8,
  parameter int BEATS_2 = 32,
  parameter int BEATS_3 = 128,
  parameter int CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_core_set,
  input  logic             i_core_mode,
  input  logic [1:0]       i_core_code,
  input  logic             i_in_valid,
  output logic             o_core_ready,
  output logic             o_mode,
  output logic [1:0]       o_code,
  output logic             o_error_bit_saver_clear,
  output logic             o_syndrome_clear_and_wen,
  output logic             o_syndrome_wen,
  output logic             o_llr_mem_wen,
  output logic [CNT_W-1:0] o_beat_idx,
  output logic             o_dec_start,
  input  logic             i_dec_done,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DECODE, OUT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, beat_idx_q;
  logic [1:0]       code_q;
  logic             mode_q;
  logic             syn_wen_q, syn_clr_q, start_pend_q, dec_start_q, armed_q;
  logic             accept, last_accept;

  function automatic logic [CNT_W-1:0] last_beat(input logic [1:0] code);
    int unsigned b;
    case (code)
      2'd0:    b = BEATS_0;
      2'd1:    b = BEATS_1;
      2'd2:    b = BEATS_2;
      default: b = BEATS_3;
    endcase
    return CNT_W'(b - 32'd1);
  endfunction

  // A new frame request always wins, so it also blocks acceptance in its own cycle.
  assign accept      = (state_q == LOAD) && i_in_valid && !i_core_set;
  assign last_accept = accept && (cnt_q == last_beat(code_q));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    o_core_ready            = 1'b0;
    o_error_bit_saver_clear = 1'b0;
    o_out_valid             = 1'b0;
    o_busy                  = (state_q != IDLE);
    if (i_core_set) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        CLEAR:   state_d = LOAD;
        LOAD:    if (last_accept) state_d = DECODE;
        DECODE:  if (armed_q && i_dec_done) state_d = OUT;
        OUT:     if (i_out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    case (state_q)
      CLEAR:   o_error_bit_saver_clear = 1'b1;
      LOAD:    o_core_ready = 1'b1;
      OUT:     o_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Strobes trail acceptance by one cycle; decoder start trails the last acceptance by two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q        <= '0;
      beat_idx_q   <= '0;
      code_q       <= '0;
      syn_wen_q    <= 1'b0;
      syn_clr_q    <= 1'b0;
      start_pend_q <= 1'b0;
      dec_start_q  <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      syn_wen_q    <= accept;
      syn_clr_q    <= accept && (cnt_q == '0);
      if (accept) beat_idx_q <= cnt_q;
      start_pend_q <= last_accept;
      dec_start_q  <= start_pend_q && !i_core_set;
      if (i_core_set || state_q != DECODE) armed_q <= 1'b0;
      else if (dec_start_q)                armed_q <= 1'b1;
      if (i_core_set || state_q == CLEAR)  cnt_q <= '0;
      else if (accept && !last_accept)     cnt_q <= cnt_q + CNT_W'(1);
      if (i_core_set) code_q <= i_core_code;
    end
  end

`ifdef SEQ_SOFT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        mode_q <= 1'b0;
    else if (i_core_set) mode_q <= i_core_mode;
  end
`else
  logic unused_mode;
  assign unused_mode = i_core_mode;
  assign mode_q      = 1'b0;
`endif

  assign o_mode                   = mode_q;
  assign o_code                   = code_q;
  assign o_syndrome_wen           = syn_wen_q;
  assign o_syndrome_clear_and_wen = syn_clr_q;
  assign o_llr_mem_wen            = syn_wen_q & mode_q;
  assign o_beat_idx               = beat_idx_q;
  assign o_dec_start              = dec_start_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: a cycle model predicts control outputs and queues expected strobes.
module tb_decode_sequencer;
  localparam int CNT_W = 8;
`ifdef SEQ_SOFT_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic i_clk = 1'b0, i_rst_n = 1'b0, i_core_set = 1'b0, i_core_mode = 1'b0;
  logic [1:0] i_core_code = 2'd0;
  logic i_in_valid = 1'b0, i_dec_done = 1'b0, i_out_ready = 1'b0;
  logic o_core_ready, o_mode, o_error_bit_saver_clear, o_syndrome_clear_and_wen;
  logic o_syndrome_wen, o_llr_mem_wen, o_dec_start, o_out_valid, o_busy;
  logic [1:0] o_code;
  logic [CNT_W-1:0] o_beat_idx;

  decode_sequencer #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_core_set(i_core_set), .i_core_mode(i_core_mode),
    .i_core_code(i_core_code), .i_in_valid(i_in_valid), .o_core_ready(o_core_ready),
    .o_mode(o_mode), .o_code(o_code), .o_error_bit_saver_clear(o_error_bit_saver_clear),
    .o_syndrome_clear_and_wen(o_syndrome_clear_and_wen), .o_syndrome_wen(o_syndrome_wen),
    .o_llr_mem_wen(o_llr_mem_wen), .o_beat_idx(o_beat_idx), .o_dec_start(o_dec_start),
    .i_dec_done(i_dec_done), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int errs = 0, checks = 0, cyc = 0;
  int n_wen = 0, n_llr = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int beats_of(input int code);
    case (code)
      0: return 8;
      1: return 8;
      2: return 32;
      default: return 128;
    endcase
  endfunction

  typedef enum int {M_IDLE, M_CLEAR, M_LOAD, M_DECODE, M_OUT} mstate_t;
  typedef struct {int idx; bit clr; bit llr;} exp_t;
  exp_t    q[$];
  mstate_t ms = M_IDLE;
  int      m_idx = 0, m_code = 0, last_acc = -100;
  bit      m_mode = 1'b0;

  logic [18:0] all_outs;
  assign all_outs = {o_core_ready, o_mode, o_code, o_error_bit_saver_clear, o_syndrome_clear_and_wen,
                     o_syndrome_wen, o_llr_mem_wen, o_beat_idx, o_dec_start, o_out_valid, o_busy};

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst_n) begin
      chk_eq("reset_outputs", 32'(all_outs), 0);
      ms = M_IDLE; q.delete(); m_idx = 0; m_code = 0; m_mode = 1'b0; last_acc = -100;
    end else begin
      chk_eq("busy", o_busy, ms != M_IDLE);
      chk_eq("core_ready", o_core_ready, ms == M_LOAD);
      chk_eq("out_valid", o_out_valid, ms == M_OUT);
      chk_eq("ebs_clear", o_error_bit_saver_clear, ms == M_CLEAR);
      chk_eq("dec_start", o_dec_start, (ms == M_DECODE) && (cyc == last_acc + 2));
      chk_eq("code", o_code, m_code);
      chk_eq("mode", o_mode, m_mode);
      if (o_syndrome_wen) begin
        n_wen++;
        if (o_llr_mem_wen) n_llr++;
        if (q.size() == 0) chk_eq("spurious_wen", 1, 0);
        else begin
          e = q.pop_front();
          chk_eq("beat_idx", o_beat_idx, e.idx);
          chk_eq("syn_clr_wen", o_syndrome_clear_and_wen, e.clr);
          chk_eq("llr_wen", o_llr_mem_wen, e.llr);
        end
      end else begin
        if (q.size() != 0) begin
          chk_eq("missing_wen", 0, 1);
          q.delete();
        end
        if ({o_syndrome_clear_and_wen, o_llr_mem_wen} != 2'b00)
          chk_eq("orphan_strobe", {o_syndrome_clear_and_wen, o_llr_mem_wen}, 0);
      end
      if (i_core_set) begin
        ms = M_CLEAR; m_code = i_core_code; m_mode = SOFT & i_core_mode;
      end else begin
        case (ms)
          M_CLEAR: begin ms = M_LOAD; m_idx = 0; end
          M_LOAD: if (i_in_valid) begin
            e.idx = m_idx; e.clr = (m_idx == 0); e.llr = m_mode;
            q.push_back(e);
            if (m_idx == beats_of(m_code) - 1) begin ms = M_DECODE; last_acc = cyc; end
            else m_idx++;
          end
          M_DECODE: if (i_dec_done && cyc > last_acc + 2) ms = M_OUT;
          M_OUT: if (i_out_ready) ms = M_IDLE;
          default: ;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic start_frame(input int code, input bit mode);
    i_core_set = 1'b1; i_core_code = 2'(code); i_core_mode = mode;
    step();
    i_core_set = 1'b0;
    n_wen = 0; n_llr = 0;
  endtask

  task automatic wait_wen(input int n, input int max);
    bit hit = 1'b0;
    for (int k = 0; k < max; k++) begin
      if (n_wen >= n) begin hit = 1'b1; break; end
      step();
    end
    if (!hit) chk_eq("timeout_wen", n_wen, n);
  endtask

  task automatic wait_dec_start(input int max);
    bit hit = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge i_clk);
      if (o_dec_start) begin hit = 1'b1; break; end
    end
    if (!hit) chk_eq("timeout_dec_start", 0, 1);
  endtask

  initial begin
    repeat (3) step();
    chk_eq("reset_async_state", 32'(all_outs), 0);
    i_rst_n = 1'b1;
    step();

    // Code 0, soft request, continuous valid, immediate result acceptance.
    i_out_ready = 1'b1;
    start_frame(0, 1'b1);
    i_in_valid = 1'b1;
    wait_dec_start(40);
    chk_eq("c0_wen_count", n_wen, 8);
    chk_eq("c0_llr_count", n_llr, SOFT ? 8 : 0);
    step(); i_dec_done = 1'b1;
    step(); i_dec_done = 1'b0;
    step(); step();
    chk_eq("c0_back_idle", o_busy, 0);
    i_dec_done = 1'b1;
    repeat (3) step();
    i_dec_done = 1'b0;

    // Code 3, hard, valid low every third cycle.
    i_in_valid = 1'b0;
    start_frame(3, 1'b0);
    for (int k = 0; k < 400; k++) begin
      i_in_valid = (k % 3) != 2;
      step();
      if (n_wen >= 128) break;
    end
    i_in_valid = 1'b0;
    wait_dec_start(10);
    chk_eq("c3_wen_count", n_wen, 128);
    chk_eq("c3_llr_count", n_llr, 0);
    step(); i_dec_done = 1'b1;
    step(); i_dec_done = 1'b0;
    step(); step();

    // Code 2 restarted by a new frame request at beat 20.
    start_frame(2, 1'b1);
    i_in_valid = 1'b1;
    wait_wen(20, 60);
    start_frame(2, 1'b1);
    @(negedge i_clk);
    chk_eq("abort_no_wen", o_syndrome_wen, 0);
    chk_eq("abort_clear", o_error_bit_saver_clear, 1);
    wait_dec_start(60);
    chk_eq("c2_restart_wen_count", n_wen, 32);
    step(); i_dec_done = 1'b1;
    step(); i_dec_done = 1'b0;
    step(); step();

    // Early decoder-done pulses ignored; result held while output not ready.
    i_out_ready = 1'b0;
    start_frame(0, 1'b0);
    i_in_valid = 1'b1;
    wait_wen(7, 20);
    i_dec_done = 1'b1;
    step();
    @(negedge i_clk);
    chk_eq("ds_after_final", o_dec_start, 1);
    step(); i_dec_done = 1'b0;
    @(negedge i_clk);
    chk_eq("early_done_ignored", o_out_valid, 0);
    repeat (3) step();
    i_dec_done = 1'b1;
    step(); i_dec_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk_eq("out_valid_held", o_out_valid, 1);
      step();
    end
    i_out_ready = 1'b1;
    step();
    @(negedge i_clk);
    chk_eq("out_done_busy", o_busy, 0);

    // Asynchronous reset at beat 50 discards the frame.
    start_frame(3, 1'b1);
    i_in_valid = 1'b1;
    wait_wen(50, 100);
    #2 i_rst_n = 1'b0;
    #1 chk_eq("async_reset_outputs", 32'(all_outs), 0);
    repeat (2) step();
    i_rst_n = 1'b1;
    n_wen = 0;
    i_dec_done = 1'b1;
    repeat (20) step();
    chk_eq("post_reset_no_wen", n_wen, 0);
    chk_eq("post_reset_idle", o_busy, 0);
    i_dec_done = 1'b0;
    i_in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
